// File: rtl/cpu_pkg.sv
// Shared CPU definitions: datapath width, 5-bit ALU opcodes and the ALU flag bundle.
package cpu_pkg;

  localparam int unsigned WIDTH = 32;

  localparam logic [4:0] OP_AND   = 5'd0;
  localparam logic [4:0] OP_EOR   = 5'd1;
  localparam logic [4:0] OP_SUB   = 5'd2;
  localparam logic [4:0] OP_RSB   = 5'd3;
  localparam logic [4:0] OP_ADD   = 5'd4;
  localparam logic [4:0] OP_ADC   = 5'd5;
  localparam logic [4:0] OP_SBC   = 5'd6;
  localparam logic [4:0] OP_RSC   = 5'd7;
  localparam logic [4:0] OP_TST   = 5'd8;
  localparam logic [4:0] OP_TEQ   = 5'd9;
  localparam logic [4:0] OP_CMP   = 5'd10;
  localparam logic [4:0] OP_CMN   = 5'd11;
  localparam logic [4:0] OP_ORR   = 5'd12;
  localparam logic [4:0] OP_MOV   = 5'd13;
  localparam logic [4:0] OP_BIC   = 5'd14;
  localparam logic [4:0] OP_MVN   = 5'd15;
  localparam logic [4:0] OP_PASSA = 5'd16;
  localparam logic [4:0] OP_PASSB = 5'd17;
  localparam logic [4:0] OP_INC4  = 5'd18;
  localparam logic [4:0] OP_DEC4  = 5'd19;

  typedef struct packed {
    logic n;
    logic z;
    logic c;
    logic v;
  } flags_t;

endpackage

// File: rtl/alu_ir_mar_datapath_if.sv
// Control/operand bus between the control unit and the ALU/IR/MAR datapath slice.
interface alu_ir_mar_datapath_if #(
  parameter int unsigned WIDTH = 32
) ();
  logic             ir_ld;
  logic             mar_ld;
  logic [WIDTH-1:0] ir_in;
  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic [4:0]       op;
  logic             carry;
  logic [WIDTH-1:0] result;
  logic             flag_z;
  logic             flag_n;
  logic             flag_c;
  logic             flag_v;
  logic [WIDTH-1:0] ir_out;
  logic [WIDTH-1:0] mar_out;

  modport master (
    output ir_ld, mar_ld, ir_in, alu_a, alu_b, op, carry,
    input  result, flag_z, flag_n, flag_c, flag_v, ir_out, mar_out
  );

  modport slave (
    input  ir_ld, mar_ld, ir_in, alu_a, alu_b, op, carry,
    output result, flag_z, flag_n, flag_c, flag_v, ir_out, mar_out
  );
endinterface

// File: rtl/alu_ir_mar_datapath_alu_core.sv
// Combinational ALU, ARM data-processing opcodes 0-15.
// ALU_EXT_OPS_EN enables opcodes 16-19 (pass A, pass B, A+4, A-4).
module alu_core
  import cpu_pkg::*;
#(
  parameter int unsigned WIDTH = cpu_pkg::WIDTH
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic [4:0]       op_i,
  input  logic             carry_i,
  output logic [WIDTH-1:0] result_o,
  output flags_t           flags_o
);

  logic [WIDTH-1:0] x, y, res;
  logic [WIDTH:0]   sum;
  logic             cin, arith, c, v;

  always_comb begin
    x     = a_i;
    y     = b_i;
    cin   = 1'b0;
    arith = 1'b0;
    res   = '0;
    c     = 1'b0;
    v     = 1'b0;
    // Subtracts are formed as x + ~y + cin so one adder yields NOT-borrow as carry.
    case (op_i)
      OP_AND, OP_TST: begin res = a_i & b_i;  c = carry_i; end
      OP_EOR, OP_TEQ: begin res = a_i ^ b_i;  c = carry_i; end
      OP_ORR:         begin res = a_i | b_i;  c = carry_i; end
      OP_MOV:         begin res = b_i;        c = carry_i; end
      OP_BIC:         begin res = a_i & ~b_i; c = carry_i; end
      OP_MVN:         begin res = ~b_i;       c = carry_i; end
      OP_SUB, OP_CMP: begin y = ~b_i; cin = 1'b1; arith = 1'b1; end
      OP_RSB:         begin x = b_i; y = ~a_i; cin = 1'b1; arith = 1'b1; end
      OP_ADD, OP_CMN: arith = 1'b1;
      OP_ADC:         begin cin = carry_i; arith = 1'b1; end
      OP_SBC:         begin y = ~b_i; cin = carry_i; arith = 1'b1; end
      OP_RSC:         begin x = b_i; y = ~a_i; cin = carry_i; arith = 1'b1; end
`ifdef ALU_EXT_OPS_EN
      OP_PASSA:       begin res = a_i; c = carry_i; end
      OP_PASSB:       begin res = b_i; c = carry_i; end
      OP_INC4:        begin y = WIDTH'(4); arith = 1'b1; end
      OP_DEC4:        begin y = ~WIDTH'(4); cin = 1'b1; arith = 1'b1; end
`endif
      default: ;
    endcase

    sum = {1'b0, x} + {1'b0, y} + {{WIDTH{1'b0}}, cin};
    if (arith) begin
      res = sum[WIDTH-1:0];
      c   = sum[WIDTH];
      v   = (x[WIDTH-1] == y[WIDTH-1]) && (res[WIDTH-1] != x[WIDTH-1]);
    end
  end

  assign result_o  = res;
  assign flags_o.n = res[WIDTH-1];
  assign flags_o.z = (res == '0);
  assign flags_o.c = c;
  assign flags_o.v = v;

endmodule

// File: rtl/alu_ir_mar_datapath.sv
// ALU + Instruction Register + Memory Address Register slice of the multicycle CPU.
// Extended opcodes 16-19 are enabled by ALU_EXT_OPS_EN (see alu_core).
module alu_ir_mar_datapath
  import cpu_pkg::*;
#(
  parameter int unsigned WIDTH = cpu_pkg::WIDTH
) (
  input logic                   CLK,
  input logic                   CLR,
  alu_ir_mar_datapath_if.slave  bus
);

  logic [WIDTH-1:0] alu_result;
  flags_t           alu_flags;
  logic [WIDTH-1:0] ir_q, mar_q;

  alu_core #(
    .WIDTH (WIDTH)
  ) u_alu_core (
    .a_i      (bus.alu_a),
    .b_i      (bus.alu_b),
    .op_i     (bus.op),
    .carry_i  (bus.carry),
    .result_o (alu_result),
    .flags_o  (alu_flags)
  );

  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      ir_q  <= '0;
      mar_q <= '0;
    end else begin
      if (bus.ir_ld)  ir_q  <= bus.ir_in;
      if (bus.mar_ld) mar_q <= alu_result;
    end
  end

  assign bus.result  = alu_result;
  assign bus.flag_n  = alu_flags.n;
  assign bus.flag_z  = alu_flags.z;
  assign bus.flag_c  = alu_flags.c;
  assign bus.flag_v  = alu_flags.v;
  assign bus.ir_out  = ir_q;
  assign bus.mar_out = mar_q;

endmodule

// File: tb/tb_alu_ir_mar_datapath.sv
// Self-checking bench for alu_ir_mar_datapath: directed vectors plus random ops vs a model.
module tb_alu_ir_mar_datapath;
  import cpu_pkg::*;

  logic CLK = 1'b0;
  logic CLR;
  int   n_checks = 0;
  int   n_errors = 0;

  alu_ir_mar_datapath_if #(.WIDTH(32)) bus ();

  alu_ir_mar_datapath #(.WIDTH(32)) dut (
    .CLK (CLK),
    .CLR (CLR),
    .bus (bus)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] obs_flags();
    return {bus.flag_n, bus.flag_z, bus.flag_c, bus.flag_v};
  endfunction

  // Reference arithmetic in 64-bit integers: carry and overflow read off the range directly.
  function automatic void do_add(input logic [31:0] x, input logic [31:0] y, input int ci,
                                 output logic [31:0] r, output logic c, output logic v);
    longint ux = longint'(x);
    longint uy = longint'(y);
    longint sx = longint'($signed(x));
    longint sy = longint'($signed(y));
    longint full = ux + uy + longint'(ci);
    longint ss = sx + sy + longint'(ci);
    r = full[31:0];
    c = (full > 64'sh0000_0000_FFFF_FFFF);
    v = (ss > 64'sh7FFF_FFFF) || (ss < -64'sh8000_0000);
  endfunction

  function automatic void do_sub(input logic [31:0] x, input logic [31:0] y, input int bw,
                                 output logic [31:0] r, output logic c, output logic v);
    longint ux = longint'(x);
    longint uy = longint'(y);
    longint sx = longint'($signed(x));
    longint sy = longint'($signed(y));
    longint full = ux - uy - longint'(bw);
    longint ss = sx - sy - longint'(bw);
    r = full[31:0];
    c = (full >= 0);
    v = (ss > 64'sh7FFF_FFFF) || (ss < -64'sh8000_0000);
  endfunction

  // Returns {result, N, Z, C, V}.
  function automatic logic [35:0] model(input logic [31:0] a, input logic [31:0] b,
                                        input logic [4:0] op, input logic cin);
    logic [31:0] r;
    logic        c, v;
    int          ci  = cin ? 1 : 0;
    int          ncb = cin ? 0 : 1;
    c = cin;
    v = 1'b0;
    case (op)
      5'd0, 5'd8:   r = a & b;
      5'd1, 5'd9:   r = a ^ b;
      5'd12:        r = a | b;
      5'd13:        r = b;
      5'd14:        r = a & ~b;
      5'd15:        r = ~b;
      5'd2, 5'd10:  do_sub(a, b, 0, r, c, v);
      5'd3:         do_sub(b, a, 0, r, c, v);
      5'd4, 5'd11:  do_add(a, b, 0, r, c, v);
      5'd5:         do_add(a, b, ci, r, c, v);
      5'd6:         do_sub(a, b, ncb, r, c, v);
      5'd7:         do_sub(b, a, ncb, r, c, v);
`ifdef ALU_EXT_OPS_EN
      5'd16:        r = a;
      5'd17:        r = b;
      5'd18:        do_add(a, 32'd4, 0, r, c, v);
      5'd19:        do_sub(a, 32'd4, 0, r, c, v);
`endif
      default: begin r = 32'd0; c = 1'b0; v = 1'b0; end
    endcase
    return {r, r[31], (r == 32'd0), c, v};
  endfunction

  task automatic set_alu(input logic [31:0] a, input logic [31:0] b, input logic [4:0] op,
                         input logic cin);
    bus.alu_a = a;
    bus.alu_b = b;
    bus.op    = op;
    bus.carry = cin;
  endtask

  task automatic alu_vec(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] op, input logic cin,
                         input logic [31:0] exp_r, input logic [3:0] exp_f);
    set_alu(a, b, op, cin);
    #1;
    check({tag, ".result"}, bus.result, exp_r);
    check({tag, ".nzcv"}, {28'd0, obs_flags()}, {28'd0, exp_f});
  endtask

  logic [31:0] exp_ir, exp_mar;
  logic [35:0] m;

  initial begin
    CLR        = 1'b0;
    bus.ir_ld  = 1'b0;
    bus.mar_ld = 1'b0;
    bus.ir_in  = 32'd0;
    set_alu(32'd0, 32'd0, OP_AND, 1'b0);
    #1;
    check("reset.ir", bus.ir_out, 32'd0);
    check("reset.mar", bus.mar_out, 32'd0);

    // Release reset, then load both registers on the first edge.
    @(negedge CLK);
    CLR        = 1'b1;
    bus.ir_ld  = 1'b1;
    bus.ir_in  = 32'hE3A0_1005;
    bus.mar_ld = 1'b1;
    set_alu(32'h40, 32'h0, OP_ADD, 1'b0);
    @(posedge CLK); #1;
    check("load.ir", bus.ir_out, 32'hE3A0_1005);
    check("load.mar", bus.mar_out, 32'h40);

    // Asynchronous clear between edges; loads held asserted must be ignored.
    bus.ir_in = 32'h1234_5678;
    set_alu(32'h77, 32'h1, OP_ADD, 1'b0);
    #2 CLR = 1'b0;
    #1;
    check("clr.async.ir", bus.ir_out, 32'd0);
    check("clr.async.mar", bus.mar_out, 32'd0);
    repeat (2) @(posedge CLK);
    #1;
    check("clr.hold.ir", bus.ir_out, 32'd0);
    check("clr.hold.mar", bus.mar_out, 32'd0);
    @(negedge CLK);
    CLR        = 1'b1;
    bus.ir_ld  = 1'b0;
    bus.mar_ld = 1'b0;

    // Directed ALU vectors (flags as {N,Z,C,V}).
    alu_vec("add.wrap",   32'hFFFF_FFFF, 32'h1, OP_ADD, 1'b0, 32'h0, 4'b0110);
    alu_vec("add.ovf",    32'h7FFF_FFFF, 32'h1, OP_ADD, 1'b0, 32'h8000_0000, 4'b1001);
    alu_vec("sub.neg",    32'd5, 32'd7, OP_SUB, 1'b0, 32'hFFFF_FFFE, 4'b1000);
    alu_vec("cmp.eq",     32'd7, 32'd7, OP_CMP, 1'b0, 32'h0, 4'b0110);
    alu_vec("adc.c1",     32'd2, 32'd3, OP_ADC, 1'b1, 32'd6, 4'b0000);
    alu_vec("bic",        32'hFF00_FF00, 32'h0F0F_0F0F, OP_BIC, 1'b0, 32'hF000_F000, 4'b1000);
    alu_vec("mvn0",       32'h0, 32'h0, OP_MVN, 1'b0, 32'hFFFF_FFFF, 4'b1000);
    alu_vec("and.cpass",  32'h0F, 32'hF0, OP_AND, 1'b1, 32'h0, 4'b0110);
    alu_vec("undef25",    32'h1234, 32'h5678, 5'd25, 1'b1, 32'h0, 4'b0100);
`ifdef ALU_EXT_OPS_EN
    alu_vec("inc4",       32'd8, 32'h0, OP_INC4, 1'b0, 32'd12, 4'b0000);
`else
    alu_vec("inc4.off",   32'd8, 32'h0, OP_INC4, 1'b0, 32'd0, 4'b0100);
`endif

    // MAR load then hold with changed operands.
    @(negedge CLK);
    set_alu(32'h100, 32'h20, OP_ADD, 1'b0);
    bus.mar_ld = 1'b1;
    @(posedge CLK); #1;
    check("mar.load", bus.mar_out, 32'h120);
    @(negedge CLK);
    bus.mar_ld = 1'b0;
    set_alu(32'h999, 32'h1, OP_SUB, 1'b0);
    @(posedge CLK); #1;
    check("mar.hold", bus.mar_out, 32'h120);

    // IR load with one-cycle latency.
    @(negedge CLK);
    bus.ir_ld = 1'b1;
    bus.ir_in = 32'hE081_0002;
    #1;
    check("ir.before", bus.ir_out, 32'hE3A0_1005 & 32'h0);
    @(posedge CLK); #1;
    check("ir.load", bus.ir_out, 32'hE081_0002);
    exp_ir  = 32'hE081_0002;
    exp_mar = 32'h120;

    // Random ops and random register loads.
    for (int i = 0; i < 300; i++) begin
      logic [31:0] a, b;
      logic [4:0]  op;
      logic        cin, ild, mld;
      @(negedge CLK);
      a   = $urandom;
      b   = $urandom;
      case ($urandom_range(0, 5))
        0: a = 32'hFFFF_FFFF;
        1: b = 32'h8000_0000;
        2: b = a;
        3: a = 32'h7FFF_FFFF;
        default: ;
      endcase
      op  = 5'($urandom_range(0, 31));
      cin = 1'($urandom_range(0, 1));
      ild = 1'($urandom_range(0, 1));
      mld = 1'($urandom_range(0, 1));
      set_alu(a, b, op, cin);
      bus.ir_ld  = ild;
      bus.mar_ld = mld;
      bus.ir_in  = $urandom;
      m = model(a, b, op, cin);
      #1;
      check($sformatf("rnd%0d.op%0d.result", i, op), bus.result, m[35:4]);
      if (op != OP_PASSA && op != OP_PASSB)
        check($sformatf("rnd%0d.op%0d.nzcv", i, op), {28'd0, obs_flags()}, {28'd0, m[3:0]});
      if (ild) exp_ir = bus.ir_in;
      if (mld) exp_mar = m[35:4];
      @(posedge CLK); #1;
      check($sformatf("rnd%0d.ir", i), bus.ir_out, exp_ir);
      check($sformatf("rnd%0d.mar", i), bus.mar_out, exp_mar);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/alu_ir_mar_datapath.md
# alu_ir_mar_datapath

Datapath slice for the multicycle CPU. It holds the 32-bit combinational ALU, the Instruction Register (IR) and the Memory Address Register (MAR). The IR captures the instruction word from memory. The MAR captures the ALU result that addresses memory. The control unit drives the opcode, carry and the two load strobes; the register file and operand muxes drive the ALU operands.

## Interface
Parameters:
- `WIDTH`, default 32: data, address and instruction width.

Ports:
- `CLK`, in, 1: single clock; all state updates on the rising edge.
- `CLR`, in, 1: reset, asynchronous, active-low. Clears IR and MAR.
- `ir_ld`, in, 1: IR load enable.
- `mar_ld`, in, 1: MAR load enable.
- `ir_in`, in, WIDTH: memory data-out word.
- `alu_a`, in, WIDTH: operand A (register file port A).
- `alu_b`, in, WIDTH: operand B (B-mux output).
- `op`, in, 5: ALU opcode.
- `carry`, in, 1: carry-in for ADC, SBC and RSC.
- `result`, out, WIDTH: ALU result.
- `flag_z`, out, 1: zero flag.
- `flag_n`, out, 1: negative flag.
- `flag_c`, out, 1: carry flag.
- `flag_v`, out, 1: overflow flag.
- `ir_out`, out, WIDTH: IR contents.
- `mar_out`, out, WIDTH: MAR contents.

## Operation
- ALU is purely combinational: `result` and flags follow `alu_a`, `alu_b`, `op` and `carry` with no register stage.
- Opcodes 0–15 use ARM data-processing encoding:
  - AND: A&B.
  - EOR: A^B.
  - SUB: A-B.
  - RSB: B-A.
  - ADD: A+B.
  - ADC: A+B+cin.
  - SBC: A-B-!cin.
  - RSC: B-A-!cin.
  - TST: A&B.
  - TEQ: A^B.
  - CMP: A-B.
  - CMN: A+B.
  - ORR: A|B.
  - MOV: B.
  - BIC: A&~B.
  - MVN: ~B.
- TST, TEQ, CMP and CMN still drive `result` (no write suppression here). Register writeback control belongs to the control unit.
- Flag rules:
  - N = result[WIDTH-1].
  - Z = (result == 0).
  - Add-type ops: C = carry-out of bit WIDTH-1; V = signed overflow, i.e. both operands the same sign and the result sign differs.
  - Subtract-type ops: C = NOT borrow (A≥B unsigned for SUB/CMP); V = operands of different sign and the result sign differs from the minuend.
  - Logical and move ops: C = `carry` passed through; V = 0.
- Extended opcodes, present only when configured (see Configuration):
  - 16: result = A.
  - 17: result = B.
  - 18: result = A+4 (PC increment), flags as ADD.
  - 19: result = A-4, flags as SUB.
- Opcodes 20–31 give result = 0, Z = 1, N = C = V = 0.
- IR: on a rising `CLK` with `ir_ld` = 1, `ir_out` ← `ir_in`; otherwise it holds.
- MAR: on a rising `CLK` with `mar_ld` = 1, `mar_out` ← `result`, the current-cycle ALU output; otherwise it holds.
- `ir_ld` and `mar_ld` are independent. Both may be asserted in the same cycle and both registers load.

## Timing
- `CLR` = 0 forces `ir_out` = 0 and `mar_out` = 0 immediately, independent of `CLK`.
- While `CLR` is held low, loads are ignored.
- Deassertion of `CLR` is synchronised by the system. The first load can occur on the first rising edge after release.
- Reset mid-operation discards the pending load. There is no partial update.
- ALU: zero-cycle latency, combinational path. The `op`/operand → `result` → MAR D path must settle within one `CLK` period.
- IR and MAR: one-cycle latency. New value is visible after the edge on which the load was sampled.

## Configuration
- `ALU_EXT_OPS_EN` defined: opcodes 16–19 behave as listed above.
- Not defined: opcodes 16–31 all follow the undefined-opcode rule (result 0, Z = 1, other flags 0).

## Structure
- Shared package `cpu_pkg` holds:
  - `WIDTH`.
  - 5-bit opcode constants, e.g. `OP_AND` … `OP_MVN`, `OP_PASSA`, `OP_PASSB`, `OP_INC4`, `OP_DEC4`.
  - A typedef for the flag bundle {N, Z, C, V}.
- One sub-module is natural: `alu_core`, the combinational ALU.
- IR and MAR are simple load-enabled registers coded inline at top level.

## Test plan
- Reset: load IR with 0xE3A01005 and MAR with 0x40, then drive `CLR` = 0 between edges → both outputs become 0 immediately and hold through 2 edges with loads asserted.
- ADD: 0xFFFFFFFF + 0x00000001 → result 0, Z = 1, C = 1, N = 0, V = 0. ADD: 0x7FFFFFFF + 1 → 0x80000000, N = 1, V = 1, C = 0.
- SUB: 5 − 7 → 0xFFFFFFFE, N = 1, C = 0. CMP: 7 vs 7 → result 0, Z = 1, C = 1. ADC with `carry` = 1: 2 + 3 → 6.
- Logic: BIC 0xFF00FF00 with B 0x0F0F0F0F → 0xF000F000. MVN of 0 → 0xFFFFFFFF, N = 1. AND with `carry` = 1 → C = 1, V = 0.
- MAR: op ADD, A = 0x100, B = 0x20, `mar_ld` = 1 → `mar_out` = 0x120 after the edge. With `mar_ld` = 0 and operands changed, it holds 0x120.
- IR/ext ops: `ir_ld` = 1 with `ir_in` = 0xE0810002 → `ir_out` updates next edge. Op 18 with A = 8 → 12 when `ALU_EXT_OPS_EN` is defined, 0 with Z = 1 when it is not.
